// File: rtl/fp32_pkg.sv
// fp32_pkg -- shared definitions for the iterative FP32 multiplier.
//
// Contents:
//   EXP_W, MAN_W, BIAS, QNAN  IEEE-754 single-precision field constants
//   state_e                   controller state enumeration
//   get_sign/get_exp/get_man  field extraction helpers
//   get_mant24                significand with the hidden one restored

package fp32_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned BIAS  = 127;
   localparam logic [31:0] QNAN  = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      StIdle,
      StMul,
      StNorm,
      StRnd,
      StDone
   } state_e;

   function automatic logic get_sign(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [EXP_W-1:0] get_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [MAN_W-1:0] get_man(input logic [31:0] x);
      return x[22:0];
   endfunction

   // Subnormals never reach the datapath (they take the flush path), so the
   // hidden bit is always one here.
   function automatic logic [MAN_W:0] get_mant24(input logic [31:0] x);
      return {1'b1, x[22:0]};
   endfunction

endpackage

// File: rtl/mant_shift_add.sv
// mant_shift_add -- iterative 24x24 shift-add significand multiplier.
//
// Retires MUL_BITS multiplier bits per cycle, so a product takes 24/MUL_BITS
// cycles after the load.
//
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   start_i  load operands and begin iterating (ignored unless idle)
//   mcand_i  24-bit multiplicand
//   mplr_i   24-bit multiplier
//   last_o   high during the cycle whose rising edge retires the final bits
//   prod_o   48-bit accumulator; complete the cycle after last_o

module mant_shift_add #(
   parameter int unsigned MUL_BITS = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [23:0] mcand_i,
   input  logic [23:0] mplr_i,
   output logic        last_o,
   output logic [47:0] prod_o
);

   localparam int unsigned ITERS = 24 / MUL_BITS;

   logic [47:0] acc_q,   acc_d;
   logic [47:0] mcand_q, mcand_d;
   logic [23:0] mplr_q,  mplr_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic        run_q,   run_d;
   logic [47:0] partial;

   always_comb begin
      // Sum of the shifted multiplicand for each set bit in the current digit.
      partial = '0;
      for (int i = 0; i < int'(MUL_BITS); i++) begin
         if (mplr_q[i]) begin
            partial = partial + (mcand_q << i);
         end
      end

      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      run_d   = run_q;

      if (start_i && !run_q) begin
         acc_d   = '0;
         mcand_d = {24'b0, mcand_i};
         mplr_d  = mplr_i;
         cnt_d   = 5'(ITERS);
         run_d   = 1'b1;
      end else if (run_q) begin
         acc_d   = acc_q + partial;
         mcand_d = mcand_q << MUL_BITS;
         mplr_d  = mplr_q >> MUL_BITS;
         cnt_d   = cnt_q - 5'd1;
         if (cnt_q == 5'd1) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
      end
   end

   assign last_o = run_q && (cnt_q == 5'd1);
   assign prod_o = acc_q;

endmodule

// File: rtl/fp32_mul_iter.sv
// fp32_mul_iter -- multi-cycle IEEE-754 single-precision multiplier.
//
// Flow: IDLE -> MUL (24/MUL_BITS cycles) -> NORM -> RND -> DONE -> IDLE.
// Zero/subnormal operands (and specials when enabled) go IDLE -> DONE.
// Rounding is to nearest-even; results with biased exponent <= 0 flush to
// signed zero.
//
// Build option: define FP_SPECIAL_EN to handle NaN/Inf operands and to
// produce Inf on overflow. Without it, exponent field 255 is an ordinary
// normal number and overflow saturates to the largest finite magnitude.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE
//   A, B   IEEE-754 single operands
//   busy   high in every state other than IDLE
//   done   one-cycle pulse when Y is valid
//   Y      product, held after done until replaced by a later result

module fp32_mul_iter
   import fp32_pkg::*;
#(
   parameter int unsigned MUL_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] Y
);

   state_e             state_q, state_d;
   logic               sign_q,  sign_d;
   logic signed [9:0]  exp_q,   exp_d;
   logic [46:0]        prod_q,  prod_d;
   logic [31:0]        y_q,     y_d;

   logic               mul_start;
   logic               mul_last;
   logic [47:0]        mul_prod;

   logic               op_sign;
   logic signed [9:0]  exp_sum;
   logic               fast_hit;
   logic [31:0]        fast_y;

   logic [23:0]        mant;
   logic               guard, rbit, sticky, rnd_up;
   logic [24:0]        mant_rnd;
   logic signed [9:0]  exp_rnd;
   logic [22:0]        man_field;
   logic [31:0]        ovf_y;
   logic [31:0]        rnd_y;

   // The operand significands are captured inside the shift-add unit on the
   // accepting edge; sign and exponent are captured here.
   mant_shift_add #(
      .MUL_BITS (MUL_BITS)
   ) u_mant_shift_add (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (mul_start),
      .mcand_i (get_mant24(A)),
      .mplr_i  (get_mant24(B)),
      .last_o  (mul_last),
      .prod_o  (mul_prod)
   );

   // Operand classification for the single-cycle path.
   always_comb begin : fast_path
      logic a_zero, b_zero;
`ifdef FP_SPECIAL_EN
      logic a_inf, b_inf, a_nan, b_nan;
`endif
      op_sign = get_sign(A) ^ get_sign(B);
      exp_sum = $signed({2'b00, get_exp(A)}) + $signed({2'b00, get_exp(B)}) - 10'sd127;
      a_zero  = (get_exp(A) == '0);
      b_zero  = (get_exp(B) == '0);
      fast_hit = 1'b0;
      fast_y   = {op_sign, 31'b0};
`ifdef FP_SPECIAL_EN
      a_inf = (get_exp(A) == 8'hFF) && (get_man(A) == '0);
      b_inf = (get_exp(B) == 8'hFF) && (get_man(B) == '0);
      a_nan = (get_exp(A) == 8'hFF) && (get_man(A) != '0);
      b_nan = (get_exp(B) == 8'hFF) && (get_man(B) != '0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         fast_hit = 1'b1;
         fast_y   = QNAN;
      end else if (a_inf || b_inf) begin
         fast_hit = 1'b1;
         fast_y   = {op_sign, 8'hFF, 23'b0};
      end else if (a_zero || b_zero) begin
         fast_hit = 1'b1;
      end
`else
      if (a_zero || b_zero) begin
         fast_hit = 1'b1;
      end
`endif
   end

   // Round-to-nearest-even on the normalized product (leading one at bit 46).
   always_comb begin : round_logic
      mant      = prod_q[46:23];
      guard     = prod_q[22];
      rbit      = prod_q[21];
      sticky    = |prod_q[20:0];
      rnd_up    = guard & (rbit | sticky | mant[0]);
      mant_rnd  = {1'b0, mant} + {24'b0, rnd_up};
      exp_rnd   = mant_rnd[24] ? exp_q + 10'sd1 : exp_q;
      man_field = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
`ifdef FP_SPECIAL_EN
      ovf_y = {sign_q, 8'hFF, 23'b0};
`else
      ovf_y = {sign_q, 31'h7F7F_FFFF};
`endif
      if (exp_rnd <= 10'sd0) begin
         rnd_y = {sign_q, 31'b0};
      end else if (exp_rnd >= 10'sd255) begin
         rnd_y = ovf_y;
      end else begin
         rnd_y = {sign_q, exp_rnd[7:0], man_field};
      end
   end

   always_comb begin : fsm_next
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      prod_d    = prod_q;
      y_d       = y_q;
      mul_start = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sign_d = op_sign;
               exp_d  = exp_sum;
               if (fast_hit) begin
                  y_d     = fast_y;
                  state_d = StDone;
               end else begin
                  mul_start = 1'b1;
                  state_d   = StMul;
               end
            end
         end
         StMul: begin
            if (mul_last) begin
               state_d = StNorm;
            end
         end
         StNorm: begin
            // Product in [2,4): drop one bit into sticky so rounding stays exact.
            if (mul_prod[47]) begin
               prod_d = {mul_prod[47:2], |mul_prod[1:0]};
               exp_d  = exp_q + 10'sd1;
            end else begin
               prod_d = mul_prod[46:0];
            end
            state_d = StRnd;
         end
         StRnd: begin
            y_d     = rnd_y;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         prod_q  <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         prod_q  <= prod_d;
         y_q     <= y_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign Y    = y_q;

endmodule

// File: tb/tb_fp32_mul_iter.sv
// tb_fp32_mul_iter -- self-checking bench for fp32_mul_iter (MUL_BITS = 1).
// Honours FP_SPECIAL_EN the same way as the design.

module tb_fp32_mul_iter;

   localparam int unsigned MB  = 1;
   localparam int          LAT = 24 / MB + 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy;
   logic        done;
   logic [31:0] Y;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fp32_mul_iter #(
      .MUL_BITS (MB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .done  (done),
      .Y     (Y)
   );

   // Reference: exact integer product, then nearest-even rounding to 24 bits.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           output bit fast);
      logic            s;
      int              ea, eb, e, sh;
      longint unsigned ma, mb, p, kept, rem, half;
      s    = a[31] ^ b[31];
      ea   = int'(a[30:23]);
      eb   = int'(b[30:23]);
      fast = 1'b1;
`ifdef FP_SPECIAL_EN
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC0_0000;
      if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC0_0000;
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
`endif
      if (ea == 0 || eb == 0) return {s, 31'h0};
      fast = 1'b0;
      ma   = 64'(a[22:0]) + (64'd1 << 23);
      mb   = 64'(b[22:0]) + (64'd1 << 23);
      p    = ma * mb;
      e    = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e++;
      end else begin
         sh = 23;
      end
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept++;
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e++;
      end
      if (e <= 0) return {s, 31'h0};
`ifdef FP_SPECIAL_EN
      if (e >= 255) return {s, 8'hFF, 23'h0};
`else
      if (e >= 255) return {s, 31'h7F7F_FFFF};
`endif
      return {s, 8'(e), kept[22:0]};
   endfunction

   // Issue one request in the next IDLE-side cycle; lat counts negedges from
   // the accepting edge to the first one where done is seen (-1 on timeout).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] y, output int lat);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      y = Y;
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      A = 32'h3F80_0000;
      B = 32'h4000_0000;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_done: got %b want 0", done);
      end
      n_checks++;
      if (Y !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_y: got %h want 00000000", Y);
      end
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored: busy %b want 0", busy);
      end
   endtask

   task automatic test_zero();
      logic [31:0] y;
      int          lat;
      do_op(32'h0000_0000, 32'h8000_0000, y, lat);
      n_checks++;
      if (y !== 32'h8000_0000) begin
         n_fail++;
         $display("FAIL zero_y: got %h want 80000000", y);
      end
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL zero_latency: got %0d want 1", lat);
      end
   endtask

   task automatic test_basic();
      logic [31:0] y;
      int          lat;
      do_op(32'hBF80_0000, 32'hBF80_0000, y, lat);
      n_checks++;
      if (y !== 32'h3F80_0000) begin
         n_fail++;
         $display("FAIL neg_one_sq_y: got %h want 3f800000", y);
      end
      n_checks++;
      if (lat !== LAT) begin
         n_fail++;
         $display("FAIL neg_one_sq_latency: got %0d want %0d", lat, LAT);
      end
      // Result exponent lands exactly on 0: flushed, but via the full datapath.
      do_op(32'h0080_0000, 32'h3F00_0000, y, lat);
      n_checks++;
      if (y !== 32'h0000_0000 || lat !== LAT) begin
         n_fail++;
         $display("FAIL underflow_flush: got %h/%0d want 00000000/%0d", y, lat, LAT);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] y;
      int          lat;
      do_op(32'h428F_4000, 32'hC120_0000, y, lat);
      n_checks++;
      if (y !== 32'hC433_1000 || lat !== LAT) begin
         n_fail++;
         $display("FAIL b2b_first: got %h/%0d want c4331000/%0d", y, lat, LAT);
      end
      do_op(32'h4521_B800, 32'h42D3_4000, y, lat);
      n_checks++;
      if (y !== 32'h4885_7316 || lat !== LAT) begin
         n_fail++;
         $display("FAIL b2b_second: got %h/%0d want 48857316/%0d", y, lat, LAT);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (Y !== 32'h4885_7316) begin
         n_fail++;
         $display("FAIL y_hold: got %h want 48857316", Y);
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      @(negedge clk);
      A = 32'h3FC0_0000;
      B = 32'h4040_0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      repeat (4) begin
         @(negedge clk);
         lat++;
      end
      A = 32'h4000_0000;
      B = 32'h4000_0000;
      start = 1'b1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL ignore_busy: got %b want 1", busy);
      end
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (Y !== 32'h4090_0000 || lat !== LAT) begin
         n_fail++;
         $display("FAIL ignore_start: got %h/%0d want 40900000/%0d", Y, lat, LAT);
      end
   endtask

   task automatic test_reset_abort();
      int pulses;
      @(negedge clk);
      A = 32'h4049_0FDB;
      B = 32'h402D_F854;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || Y !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_state: busy %b done %b y %h want 0 0 00000000", busy, done, Y);
      end
      rst_n = 1'b1;
      start = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) pulses++;
      end
      n_checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: done pulses %0d busy %b want 0 0", pulses, busy);
      end
   endtask

   task automatic test_special();
      logic [31:0] y;
      int          lat;
`ifdef FP_SPECIAL_EN
      do_op(32'h7F80_0000, 32'h0000_0000, y, lat);
      n_checks++;
      if (y !== 32'h7FC0_0000 || lat !== 1) begin
         n_fail++;
         $display("FAIL inf_times_zero: got %h/%0d want 7fc00000/1", y, lat);
      end
      do_op(32'h7F00_0000, 32'h7F00_0000, y, lat);
      n_checks++;
      if (y !== 32'h7F80_0000 || lat !== LAT) begin
         n_fail++;
         $display("FAIL overflow_inf: got %h/%0d want 7f800000/%0d", y, lat, LAT);
      end
`else
      do_op(32'h7F00_0000, 32'h7F00_0000, y, lat);
      n_checks++;
      if (y !== 32'h7F7F_FFFF || lat !== LAT) begin
         n_fail++;
         $display("FAIL overflow_sat: got %h/%0d want 7f7fffff/%0d", y, lat, LAT);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] a, b, y, exp_y;
      bit          fast;
      int          lat, exp_lat;
      for (int i = 0; i < 60; i++) begin
         case (i % 3)
            0: begin
               a = $urandom();
               b = $urandom();
            end
            1: begin
               a = {1'($urandom()), 8'($urandom_range(100, 154)), 23'($urandom())};
               b = {1'($urandom()), 8'($urandom_range(100, 154)), 23'($urandom())};
            end
            default: begin
               a = $urandom();
               b = {1'($urandom()), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                    ($urandom_range(0, 1) != 0) ? 23'($urandom()) : 23'h0};
            end
         endcase
         exp_y   = ref_mul(a, b, fast);
         exp_lat = fast ? 1 : LAT;
         do_op(a, b, y, lat);
         n_checks++;
         if (y !== exp_y || lat !== exp_lat) begin
            n_fail++;
            $display("FAIL random_%0d: a %h b %h got %h/%0d want %h/%0d",
                     i, a, b, y, lat, exp_y, exp_lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_basic();
      test_back_to_back();
      test_start_ignored();
      test_reset_abort();
      test_special();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
